// File: rtl/fifo_param_pkg.sv
// Shared types and width helpers for the parameterised single-clock FIFO.
package fifo_param_pkg;

    typedef enum logic {
        MODE_STD  = 1'b0,
        MODE_FWFT = 1'b1
    } read_mode_e;

    function automatic int ptr_width(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_param_mem.sv
// FIFO storage: synchronous write, asynchronous read, no reset on the array.
module fifo_param_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_param.sv
// Parameterised synchronous FIFO with occupancy, thresholds, optional FWFT read,
// flush and sticky overflow/underflow flags.
module fifo_param
    import fifo_param_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          Wr_enable,
    input  logic [WIDTH-1:0]              data_in,
    input  logic                          Read_enable,
    input  logic                          clr_err,
    output logic [WIDTH-1:0]              data_out,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [cnt_width(DEPTH)-1:0]   count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = cnt_width(DEPTH);
    localparam read_mode_e MODE = (FWFT != 0) ? MODE_FWFT : MODE_STD;
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

    if (AF_LEVEL < 0 || AF_LEVEL > DEPTH) begin : g_bad_af
        $error("fifo_param: AF_LEVEL must lie in 0..DEPTH");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH) begin : g_bad_ae
        $error("fifo_param: AE_LEVEL must lie in 0..DEPTH");
    end

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic             rd_acc, wr_acc, do_rd, do_wr;
    logic [WIDTH-1:0] rd_word;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    assign full         = (count_q == CNT_FULL);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_CNT);
    assign almost_empty = (count_q <= AE_CNT);
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

    // A read frees a slot in the same cycle, so a write to a full FIFO is accepted alongside it.
    assign rd_acc = Read_enable & ~empty;
    assign wr_acc = Wr_enable & (~full | Read_enable);
    assign do_rd  = rd_acc & ~flush;
    assign do_wr  = wr_acc & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_wr) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_rd) rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CW'(wr_acc) - CW'(rd_acc);
        end
    end

    // Error flags: a new rejection wins over a clear in the same cycle.
    always_comb begin
        ovf_d = clr_err ? 1'b0 : ovf_q;
        unf_d = clr_err ? 1'b0 : unf_q;
        if (~flush & Wr_enable & ~wr_acc)   ovf_d = 1'b1;
        if (~flush & Read_enable & ~rd_acc) unf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    fifo_param_mem #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .AW   (PW)
    ) u_mem (
        .clk  (clk),
        .we   (do_wr),
        .waddr(wr_ptr_q),
        .wdata(data_in),
        .raddr(rd_ptr_q),
        .rdata(rd_word)
    );

    if (MODE == MODE_FWFT) begin : g_fwft
        assign data_out = empty ? '0 : rd_word;
    end else begin : g_std
        logic [WIDTH-1:0] dout_q;
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                dout_q <= '0;
            end else if (do_rd) begin
                dout_q <= rd_word;
            end
        end
        assign data_out = dout_q;
    end

endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
- Parametrised synchronous FIFO, next generation of the team's single-clock FIFO; generalised in data width and depth.
- Adds:
  - occupancy count output
  - programmable almost-full / almost-empty thresholds
  - selectable first-word-fall-through (FWFT) read mode
  - synchronous flush
  - sticky overflow/underflow error flags
- Sits between a producer and a consumer in the same clock domain; drop-in for the existing FIFO when FWFT=0.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 16, number of storage entries (>=2, any integer; not restricted to a power of two).
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL.
- FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously to clk.
- flush  input  1  synchronous clear of contents (pointers and count to 0).
- Wr_enable  input  1  write request.
- data_in  input  WIDTH  write data.
- Read_enable  input  1  read request.
- data_out  output  WIDTH  read data.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_LEVEL.
- almost_empty  output  1  count <= AE_LEVEL.
- count  output  $clog2(DEPTH+1)  current occupancy.
- overflow  output  1  sticky: write rejected.
- underflow  output  1  sticky: read rejected.
- clr_err  input  1  synchronous clear of overflow/underflow.

Behaviour:
- Reset (reset=0, asynchronous):
  - write_ptr, read_ptr, count = 0; data_out = 0.
  - empty=1, full=0, almost_empty=1, almost_full=0 (for AF_LEVEL>0).
  - overflow = underflow = 0.
  - Storage contents are don't-care.
- Accept rules, combinational from current state:
  - rd_acc = Read_enable & !empty
  - wr_acc = Wr_enable & (!full | Read_enable)
  - When full, a simultaneous read and write are both accepted and count stays at DEPTH.
  - When empty, a simultaneous read and write: write accepted, read rejected, and underflow sets.
- Pointers:
  - On each accept, the pointer advances by 1 on the next edge.
  - Wraps from DEPTH-1 to 0; width $clog2(DEPTH).
- Count update: count_next = count + wr_acc - rd_acc; always within 0..DEPTH.
- Flags (full, empty, almost_*) are derived combinationally from registered count, so they track count with no extra latency.
- FWFT=0:
  - data_out is registered; it loads mem[read_ptr] on the edge where rd_acc=1, so valid one cycle after the accepted read.
  - data_out holds its value otherwise.
- FWFT=1:
  - data_out = mem[read_ptr] whenever !empty.
  - Read_enable acts as pop/acknowledge.
  - data_out = 0 when empty.
  - A word written into an empty FIFO appears on data_out the cycle after the write edge.
- Error flags:
  - overflow sets on Wr_enable & !wr_acc.
  - underflow sets on Read_enable & !rd_acc.
  - Both hold until clr_err=1 or reset. Set has priority over clr_err in the same cycle.
- flush=1:
  - Next edge: pointers = 0, count = 0; any reads or writes in that cycle are ignored.
  - Error flags are unaffected; data_out holds its value (FWFT=1: goes to 0 via empty).
- Reset mid-operation: all state is cleared immediately regardless of pending requests.
- Threshold parameters outside 0..DEPTH are a compile-time error (elaboration assertion).

Decomposition:
- Package fifo_param_pkg holds:
  - the typedef for read-mode enumeration (MODE_STD, MODE_FWFT)
  - the width helper functions for pointer and count widths.
- One sub-module fifo_param_mem:
  - DEPTH x WIDTH register array
  - synchronous write port, asynchronous read port
  - no reset on the storage.
- Control (pointers, count, flags, output register) stays in fifo_param.

Test Plan:
- Fill/drain, DEPTH=16, FWFT=0: write 0x01..0x10 on 16 consecutive cycles -> full=1, count=16, almost_full from count 14. Then read 16 -> data_out 0x01..0x10, each one cycle after its read; empty=1.
- Full with simultaneous read+write: write 0xAA -> both accepted, count stays 16, overflow=0. The next 16 reads return 0x02..0x10 then 0xAA.
- Overflow/underflow sticky:
  - Write when full with Read_enable=0 -> overflow=1, count=16, contents unchanged.
  - Read when empty -> underflow=1.
  - Pulse clr_err -> both 0 on the next cycle.
- FWFT=1: write 0x5A into empty FIFO -> data_out=0x5A on the following cycle with no read. Read_enable pop -> empty=1, data_out=0.
- Wrap with DEPTH=5: 12 interleaved write/read pairs -> pointers wrap 4->0, data order preserved, count never exceeds 5.
- Flush and async reset:
  - flush at count=7 -> count=0, empty=1 next cycle, error flags kept.
  - reset=0 asserted mid-burst between edges -> all outputs go to their reset values before the next edge.
